// File: rtl/sha256_pkg.sv
// Shared constants, block-count helper and FSM state encoding for the SHA-256 block padder.
package sha256_pkg;

   localparam int BLOCK_W     = 512;
   localparam int LEN_FIELD_W = 64;
   // one '1' bit plus the 64-bit length field, rounded up to a whole byte
   localparam int PAD_RESERVE = 72;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BUILD = 2'd1,
      EMIT  = 2'd2
   } pad_state_e;

   function automatic int unsigned num_blocks(input int unsigned len);
      return (len + LEN_FIELD_W) / BLOCK_W + 1;
   endfunction

endpackage

// File: rtl/sha256_pad_align.sv
// Combinational padding network: left-aligns the message, appends the '1' marker bit
// and drops the 64-bit length field into the tail of the final block.
module sha256_pad_align
   import sha256_pkg::*;
#(
   parameter int MAX_BLOCKS   = 4,
   parameter int MAX_MSG_BITS = MAX_BLOCKS * BLOCK_W - PAD_RESERVE,
   parameter int LEN_W        = $clog2(MAX_MSG_BITS + 1),
   parameter int IDX_W        = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1
) (
   input  logic [MAX_MSG_BITS-1:0]        msg,
   input  logic [LEN_W-1:0]               len,
   output logic [MAX_BLOCKS*BLOCK_W-1:0]  padded,
   output logic [IDX_W-1:0]               last_idx
);

   localparam int PAD_W = MAX_BLOCKS * BLOCK_W;

   logic [PAD_W-1:0] msg_left;
   logic [PAD_W-1:0] one_bit;
   logic [PAD_W-1:0] len_field;
   logic [LEN_W-1:0] shift_amt;
   int unsigned      n_blk;

   // Bits of msg above len-1 are shifted out of the top, so stale upper bits never leak.
   always_comb begin
      n_blk     = num_blocks(32'(len));
      shift_amt = LEN_W'(MAX_MSG_BITS) - len;
      msg_left  = {msg, {PAD_RESERVE{1'b0}}} << shift_amt;
      one_bit   = {1'b1, {(PAD_W-1){1'b0}}} >> len;
      len_field = PAD_W'(len) << ((MAX_BLOCKS - n_blk) * BLOCK_W);
      padded    = msg_left | one_bit | len_field;
      last_idx  = IDX_W'(n_blk - 1);
   end

endmodule

// File: rtl/sha256_block_padder.sv
// SHA-256 message padder: captures a right-aligned message, builds the padded buffer
// once, then streams it one 512-bit block per valid/ready handshake.
//
// state | meaning
// IDLE  | waiting for start; length check on request
// BUILD | register padded buffer and block count (one cycle)
// EMIT  | present block idx_q; advance on handshake, finish after the last one
module sha256_block_padder
   import sha256_pkg::*;
#(
   parameter  int MAX_BLOCKS   = 4,
   localparam int MAX_MSG_BITS = MAX_BLOCKS * BLOCK_W - PAD_RESERVE,
   localparam int LEN_W        = $clog2(MAX_MSG_BITS + 1),
   localparam int IDX_W        = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic [MAX_MSG_BITS-1:0] msg_in,
   input  logic [LEN_W-1:0]        msg_len,
   input  logic                    abort,
   output logic                    busy,
   output logic                    len_err,
   output logic                    blk_valid,
   input  logic                    blk_ready,
   output logic [BLOCK_W-1:0]      blk_data,
   output logic [IDX_W-1:0]        blk_idx,
   output logic                    blk_last,
   output logic                    done
);

   localparam int PAD_W = MAX_BLOCKS * BLOCK_W;

   pad_state_e state, state_nxt;

   logic [MAX_MSG_BITS-1:0] msg_q;
   logic [LEN_W-1:0]        len_q;
   logic [PAD_W-1:0]        pad_q;
   logic [PAD_W-1:0]        pad_w;
   logic [IDX_W-1:0]        last_idx_q;
   logic [IDX_W-1:0]        last_idx_w;
   logic [IDX_W-1:0]        idx_q;
   logic                    len_err_q;
   logic                    done_q;

   logic len_ok;
   logic accept;
   logic hs;
   logic final_hs;
   logic at_last;

   sha256_pad_align #(
      .MAX_BLOCKS   (MAX_BLOCKS),
      .MAX_MSG_BITS (MAX_MSG_BITS),
      .LEN_W        (LEN_W),
      .IDX_W        (IDX_W)
   ) u_align (
      .msg      (msg_q),
      .len      (len_q),
      .padded   (pad_w),
      .last_idx (last_idx_w)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // abort takes priority over a handshake, so a final block aborted in flight never signals done
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      hs        = 1'b0;
      final_hs  = 1'b0;
      len_ok    = (msg_len <= LEN_W'(MAX_MSG_BITS));
      at_last   = (idx_q == last_idx_q);
      busy      = (state != IDLE);
      blk_valid = 1'b0;
      blk_last  = 1'b0;
      blk_data  = '0;
      blk_idx   = idx_q;
      len_err   = len_err_q;
      done      = done_q;
      case (state)
         IDLE: begin
            if (start && len_ok) begin
               accept    = 1'b1;
               state_nxt = BUILD;
            end
         end
         BUILD: begin
            state_nxt = abort ? IDLE : EMIT;
         end
         EMIT: begin
            blk_valid = 1'b1;
            blk_last  = at_last;
            blk_data  = pad_q[(MAX_BLOCKS - 1 - int'(idx_q)) * BLOCK_W +: BLOCK_W];
            hs        = blk_ready && !abort;
            final_hs  = hs && at_last;
            if (abort || final_hs) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         msg_q      <= '0;
         len_q      <= '0;
         pad_q      <= '0;
         last_idx_q <= '0;
         idx_q      <= '0;
         len_err_q  <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         len_err_q <= (state == IDLE) && start && !len_ok;
         done_q    <= final_hs;
         if (accept) begin
            msg_q <= msg_in;
            len_q <= msg_len;
         end
         if (state == BUILD) begin
            pad_q      <= pad_w;
            last_idx_q <= last_idx_w;
            idx_q      <= '0;
         end else if (hs && !final_hs) begin
            idx_q <= idx_q + IDX_W'(1);
         end else if (state_nxt == IDLE) begin
            idx_q <= '0;
         end
      end
   end

endmodule

// File: tb/tb_sha256_block_padder.sv
// Scoreboard bench for sha256_block_padder: directed messages push hand-computed blocks,
// a negedge monitor pops and compares on every handshake.
module tb_sha256_block_padder;
   import sha256_pkg::*;

   localparam int MAX_BLOCKS   = 4;
   localparam int MAX_MSG_BITS = MAX_BLOCKS * 512 - 72;
   localparam int LEN_W        = $clog2(MAX_MSG_BITS + 1);
   localparam int IDX_W        = (MAX_BLOCKS > 1) ? $clog2(MAX_BLOCKS) : 1;

   logic                    clk = 1'b0;
   logic                    rst;
   logic                    start;
   logic [MAX_MSG_BITS-1:0] msg_in;
   logic [LEN_W-1:0]        msg_len;
   logic                    abort;
   logic                    busy;
   logic                    len_err;
   logic                    blk_valid;
   logic                    blk_ready;
   logic [511:0]            blk_data;
   logic [IDX_W-1:0]        blk_idx;
   logic                    blk_last;
   logic                    done;

   sha256_block_padder #(.MAX_BLOCKS(MAX_BLOCKS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .msg_in    (msg_in),
      .msg_len   (msg_len),
      .abort     (abort),
      .busy      (busy),
      .len_err   (len_err),
      .blk_valid (blk_valid),
      .blk_ready (blk_ready),
      .blk_data  (blk_data),
      .blk_idx   (blk_idx),
      .blk_last  (blk_last),
      .done      (done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [511:0]     data;
      logic [IDX_W-1:0] idx;
      logic             last;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h required %h", name, act, req);
      end
   endtask

   task automatic push(input logic [511:0] d, input int idx, input logic last);
      exp_t e;
      e.data = d;
      e.idx  = IDX_W'(idx);
      e.last = last;
      exp_q.push_back(e);
   endtask

   task automatic send(input logic [MAX_MSG_BITS-1:0] m, input int len);
      @(posedge clk); #1;
      msg_in  = m;
      msg_len = LEN_W'(len);
      start   = 1'b1;
      @(posedge clk); #1;
      start   = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while ((exp_q.size() != 0 || busy) && n < 60) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0 || busy) begin
         errors++;
         $display("FAIL %s_drain: outstanding=%0d busy=%b, required 0 and 0", name, exp_q.size(), busy);
         exp_q.delete();
      end
      @(negedge clk);
      @(negedge clk);
   endtask

   // monitor
   exp_t             mon_e;
   logic             exp_done = 1'b0;
   logic             prev_stall = 1'b0;
   logic [511:0]     prev_data;
   logic [IDX_W-1:0] prev_idx;
   logic             prev_last;

   always @(negedge clk) begin
      if (exp_done || done === 1'b1) check("done_pulse", 512'(done), 512'(exp_done));
      if (prev_stall) begin
         checks++;
         if (blk_valid !== 1'b1 || blk_data !== prev_data || blk_idx !== prev_idx || blk_last !== prev_last) begin
            errors++;
            $display("FAIL stall_hold: valid=%b idx=%0d last=%b, required valid=1 idx=%0d last=%b with data unchanged",
                     blk_valid, blk_idx, blk_last, prev_idx, prev_last);
         end
      end
      exp_done = 1'b0;
      if (blk_valid === 1'b1 && blk_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_block: idx=%0d last=%b, required no block", blk_idx, blk_last);
         end else begin
            mon_e = exp_q.pop_front();
            check("blk_data", blk_data, mon_e.data);
            check("blk_idx", 512'(blk_idx), 512'(mon_e.idx));
            check("blk_last", 512'(blk_last), 512'(mon_e.last));
            exp_done = blk_last && !abort && !rst;
         end
      end
      prev_stall = (blk_valid === 1'b1) && !blk_ready && !abort && !rst;
      prev_data  = blk_data;
      prev_idx   = blk_idx;
      prev_last  = blk_last;
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      logic [MAX_MSG_BITS-1:0] ones;
      logic [MAX_MSG_BITS-1:0] m;
      ones      = '1;
      rst       = 1'b1;
      start     = 1'b0;
      abort     = 1'b0;
      blk_ready = 1'b1;
      msg_in    = '0;
      msg_len   = '0;

      repeat (2) @(negedge clk);
      check("rst_busy", 512'(busy), 512'(0));
      check("rst_len_err", 512'(len_err), 512'(0));
      check("rst_valid", 512'(blk_valid), 512'(0));
      check("rst_last", 512'(blk_last), 512'(0));
      check("rst_done", 512'(done), 512'(0));
      check("rst_idx", 512'(blk_idx), 512'(0));
      check("rst_data", blk_data, 512'(0));
      @(posedge clk); #1;
      rst = 1'b0;

      // "a" (0x61), 8 bits: latency start -> BUILD -> EMIT
      push({8'h61, 1'b1, 439'b0, 64'd8}, 0, 1'b1);
      m = '0; m[7:0] = 8'h61;
      send(m, 8);
      @(negedge clk);
      check("lat_build_valid", 512'(blk_valid), 512'(0));
      check("lat_build_busy", 512'(busy), 512'(1));
      @(negedge clk);
      check("lat_emit_valid", 512'(blk_valid), 512'(1));
      drain("msg_61");

      // 512-bit message: a single 1 then zeros
      push({1'b1, 511'b0}, 0, 1'b0);
      push({1'b1, 447'b0, 64'h200}, 1, 1'b1);
      m = '0; m[511] = 1'b1;
      send(m, 512);
      drain("len_512");

      // empty message
      push({1'b1, 511'b0}, 0, 1'b1);
      send('0, 0);
      drain("len_0");

      // boundary lengths with all-ones message
      push({{448{1'b1}}, 64'h1BF}, 0, 1'b1);
      send(ones, 447);
      drain("len_447");

      push({{449{1'b1}}, 63'b0}, 0, 1'b0);
      push({448'b0, 64'h1C0}, 1, 1'b1);
      send(ones, 448);
      drain("len_448");

      push({512{1'b1}}, 0, 1'b0);
      push({{448{1'b1}}, 64'h3BF}, 1, 1'b1);
      send(ones, 959);
      drain("len_959");

      push({512{1'b1}}, 0, 1'b0);
      push({512{1'b1}}, 1, 1'b0);
      push({512{1'b1}}, 2, 1'b0);
      push({{441{1'b1}}, 7'b0, 64'h7B8}, 3, 1'b1);
      send(ones, 1976);
      drain("len_1976");

      // 960 bits, stall 3 cycles on block 1, start and msg_in changes while busy
      push({512{1'b1}}, 0, 1'b0);
      push({{449{1'b1}}, 63'b0}, 1, 1'b0);
      push({448'b0, 64'h3C0}, 2, 1'b1);
      send(ones, 960);
      @(posedge clk);
      @(posedge clk); #1;
      blk_ready = 1'b0;
      start     = 1'b1;
      msg_in    = '0;
      msg_len   = LEN_W'(8);
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      blk_ready = 1'b1;
      drain("stall_960");

      // over-length request
      send(ones, 1977);
      @(negedge clk);
      check("lerr_pulse", 512'(len_err), 512'(1));
      check("lerr_busy", 512'(busy), 512'(0));
      check("lerr_valid", 512'(blk_valid), 512'(0));
      @(negedge clk);
      check("lerr_pulse_end", 512'(len_err), 512'(0));
      check("lerr_busy2", 512'(busy), 512'(0));
      repeat (2) @(negedge clk);

      // abort while block 1 is stalled
      push({512{1'b1}}, 0, 1'b0);
      send(ones, 960);
      @(posedge clk);
      @(posedge clk); #1;
      blk_ready = 1'b0;
      @(negedge clk);
      check("abort_pre_valid", 512'(blk_valid), 512'(1));
      check("abort_pre_idx", 512'(blk_idx), 512'(1));
      @(posedge clk); #1;
      abort = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_valid", 512'(blk_valid), 512'(0));
      check("abort_busy", 512'(busy), 512'(0));
      blk_ready = 1'b1;
      drain("abort_960");

      // reset while presenting a block
      blk_ready = 1'b0;
      m = '0; m[7:0] = 8'h61;
      send(m, 8);
      @(negedge clk);
      @(negedge clk);
      check("rst_emit_pre_valid", 512'(blk_valid), 512'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_emit_valid", 512'(blk_valid), 512'(0));
      check("rst_emit_busy", 512'(busy), 512'(0));
      check("rst_emit_data", blk_data, 512'(0));
      blk_ready = 1'b1;
      drain("rst_emit");

      // abort coinciding with the final handshake: no done
      blk_ready = 1'b0;
      push({8'h61, 1'b1, 439'b0, 64'd8}, 0, 1'b1);
      send(m, 8);
      @(negedge clk);
      @(negedge clk);
      @(posedge clk); #1;
      abort     = 1'b1;
      blk_ready = 1'b1;
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      check("abort_last_done", 512'(done), 512'(0));
      check("abort_last_valid", 512'(blk_valid), 512'(0));
      drain("abort_last");

      check("scoreboard_empty", 512'(exp_q.size()), 512'(0));
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
